// File: rtl/vx_writeback_arb_if.sv
// Writeback arbiter bus: per-channel result inputs and the single register-file write port.
interface vx_writeback_arb_if #(
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_WARPS   = 8
);
  localparam int unsigned WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned DW = NUM_THREADS * 32;

  logic [NUM_SRC-1:0]             in_valid;
  logic [NUM_SRC-1:0]             in_ready;
  logic [NUM_SRC*DW-1:0]          in_alu_result;
  logic [NUM_SRC*DW-1:0]          in_mem_result;
  logic [NUM_SRC*32-1:0]          in_PC_next;
  logic [NUM_SRC*5-1:0]           in_rd;
  logic [NUM_SRC*2-1:0]           in_wb;
  logic [NUM_SRC*NUM_THREADS-1:0] in_thread_mask;
  logic [NUM_SRC*WW-1:0]          in_warp_num;

  logic                           out_valid;
  logic [DW-1:0]                  out_write_data;
  logic [4:0]                     out_rd;
  logic [1:0]                     out_wb;
  logic [NUM_THREADS-1:0]         out_thread_mask;
  logic [WW-1:0]                  out_warp_num;
  logic [SW-1:0]                  out_sel;

  modport master (
    output in_valid, in_alu_result, in_mem_result, in_PC_next, in_rd, in_wb,
           in_thread_mask, in_warp_num,
    input  in_ready, out_valid, out_write_data, out_rd, out_wb, out_thread_mask,
           out_warp_num, out_sel
  );

  modport slave (
    input  in_valid, in_alu_result, in_mem_result, in_PC_next, in_rd, in_wb,
           in_thread_mask, in_warp_num,
    output in_ready, out_valid, out_write_data, out_rd, out_wb, out_thread_mask,
           out_warp_num, out_sel
  );
endinterface

// File: rtl/vx_writeback_arb.sv
// Multi-source writeback: per-channel circular FIFOs, round-robin pop, one registered
// register-file write port. Link/ALU/MEM data is chosen at enqueue time.
module vx_writeback_arb #(
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_WARPS   = 8,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                clk,
  input  logic                reset,
  vx_writeback_arb_if.slave   bus
);
  localparam int unsigned NT = NUM_THREADS;
  localparam int unsigned DW = NT * 32;
  localparam int unsigned WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // FIFO storage (contents are don't-care until the pointers say otherwise)
  logic [DW-1:0]  r_mem_data [NUM_SRC][DEPTH];
  logic [4:0]     r_mem_rd   [NUM_SRC][DEPTH];
  logic [1:0]     r_mem_wb   [NUM_SRC][DEPTH];
  logic [NT-1:0]  r_mem_mask [NUM_SRC][DEPTH];
  logic [WW-1:0]  r_mem_warp [NUM_SRC][DEPTH];

  logic [PW-1:0]  r_head  [NUM_SRC];
  logic [PW-1:0]  r_tail  [NUM_SRC];
  logic [CW-1:0]  r_count [NUM_SRC];
  logic [SW-1:0]  r_prio;

  logic           r_out_valid;
  logic [DW-1:0]  r_out_data;
  logic [4:0]     r_out_rd;
  logic [1:0]     r_out_wb;
  logic [NT-1:0]  r_out_mask;
  logic [WW-1:0]  r_out_warp;
  logic [SW-1:0]  r_out_sel;

  logic [DW-1:0]  w_in_data [NUM_SRC];
  logic [4:0]     w_in_rd   [NUM_SRC];
  logic [1:0]     w_in_wb   [NUM_SRC];
  logic [NT-1:0]  w_in_mask [NUM_SRC];
  logic [WW-1:0]  w_in_warp [NUM_SRC];
  logic [NUM_SRC-1:0] w_ready;
  logic [NUM_SRC-1:0] w_nonempty;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic           w_any;
  logic [SW-1:0]  w_grant;
  logic [SW-1:0]  w_prio_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Unpack channel inputs, pick the write data, qualify pushes
  always_comb begin
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      w_in_rd[s]   = bus.in_rd[s*5 +: 5];
      w_in_wb[s]   = bus.in_wb[s*2 +: 2];
      w_in_mask[s] = bus.in_thread_mask[s*NT +: NT];
      w_in_warp[s] = bus.in_warp_num[s*WW +: WW];
      w_in_data[s] = bus.in_mem_result[s*DW +: DW];
      if (w_in_wb[s] == 2'd3) begin
        for (int unsigned t = 0; t < NT; t++) begin
          w_in_data[s][t*32 +: 32] = bus.in_PC_next[s*32 +: 32];
        end
      end else if (w_in_wb[s] == 2'd1) begin
        w_in_data[s] = bus.in_alu_result[s*DW +: DW];
      end
      w_ready[s]    = (r_count[s] != CW'(DEPTH));
      w_nonempty[s] = (r_count[s] != '0);
      // Entries that would write nothing complete the handshake but are not stored
      w_push[s] = bus.in_valid[s] && w_ready[s] && (w_in_wb[s] != 2'd0) &&
                  (w_in_rd[s] != 5'd0) && (w_in_mask[s] != '0);
    end
  end

  // Round-robin search starting at the priority pointer
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_any   = 1'b0;
    w_grant = '0;
    w_pop   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = 32'(r_prio) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!w_any && w_nonempty[SW'(idx)]) begin
        w_any   = 1'b1;
        w_grant = SW'(idx);
      end
    end
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      w_pop[s] = w_any && (w_grant == SW'(s));
    end
    w_prio_next = (w_grant == SW'(NUM_SRC - 1)) ? '0 : w_grant + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        r_head[s]  <= '0;
        r_tail[s]  <= '0;
        r_count[s] <= '0;
      end
      r_prio <= '0;
    end else begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (w_push[s]) r_tail[s] <= ptr_inc(r_tail[s]);
        if (w_pop[s])  r_head[s] <= ptr_inc(r_head[s]);
        case ({w_push[s], w_pop[s]})
          2'b10:   r_count[s] <= r_count[s] + CW'(1);
          2'b01:   r_count[s] <= r_count[s] - CW'(1);
          default: r_count[s] <= r_count[s];
        endcase
      end
      if (w_any) r_prio <= w_prio_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (w_push[s]) begin
        r_mem_data[s][r_tail[s]] <= w_in_data[s];
        r_mem_rd[s][r_tail[s]]   <= w_in_rd[s];
        r_mem_wb[s][r_tail[s]]   <= w_in_wb[s];
        r_mem_mask[s][r_tail[s]] <= w_in_mask[s];
        r_mem_warp[s][r_tail[s]] <= w_in_warp[s];
      end
    end
  end

  // Write port register: strobe every cycle, payload only on a pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
      r_out_wb    <= '0;
      r_out_mask  <= '0;
      r_out_warp  <= '0;
      r_out_sel   <= '0;
    end else begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= r_mem_data[w_grant][r_head[w_grant]];
        r_out_rd   <= r_mem_rd[w_grant][r_head[w_grant]];
        r_out_wb   <= r_mem_wb[w_grant][r_head[w_grant]];
        r_out_mask <= r_mem_mask[w_grant][r_head[w_grant]];
        r_out_warp <= r_mem_warp[w_grant][r_head[w_grant]];
        r_out_sel  <= w_grant;
      end
    end
  end

  assign bus.in_ready        = w_ready;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_write_data  = r_out_data;
  assign bus.out_rd          = r_out_rd;
  assign bus.out_wb          = r_out_wb;
  assign bus.out_thread_mask = r_out_mask;
  assign bus.out_warp_num    = r_out_warp;
  assign bus.out_sel         = r_out_sel;
endmodule

// File: tb/tb_vx_writeback_arb.sv
// Directed bench for vx_writeback_arb: single-entry vector table, a 3-channel burst
// against a queue model, and a mid-burst reset.
module tb_vx_writeback_arb;
  localparam int unsigned NS = 3;
  localparam int unsigned NT = 4;
  localparam int unsigned NW = 8;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  vx_writeback_arb_if #(.NUM_SRC(NS), .NUM_THREADS(NT), .NUM_WARPS(NW)) bus ();

  vx_writeback_arb #(.NUM_SRC(NS), .NUM_THREADS(NT), .NUM_WARPS(NW), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [3:0]  mask;
    logic [2:0]  warp;
    logic [127:0] alu;
    logic [127:0] mem;
    logic [31:0] pc;
    logic        exp_valid;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs [8];
  logic [31:0] mq [NS][$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [127:0] lanes(input logic [31:0] b);
    logic [127:0] r;
    for (int t = 0; t < 4; t++) r[t*32 +: 32] = b + 32'(t);
    return r;
  endfunction

  task automatic clear_inputs();
    bus.in_valid       = '0;
    bus.in_alu_result  = '0;
    bus.in_mem_result  = '0;
    bus.in_PC_next     = '0;
    bus.in_rd          = '0;
    bus.in_wb          = '0;
    bus.in_thread_mask = '0;
    bus.in_warp_num    = '0;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] wb, input logic [4:0] rd,
                        input logic [3:0] mask, input logic [2:0] warp,
                        input logic [127:0] alu, input logic [127:0] mem, input logic [31:0] pc);
    bus.in_valid[ch]             = 1'b1;
    bus.in_wb[ch*2 +: 2]         = wb;
    bus.in_rd[ch*5 +: 5]         = rd;
    bus.in_thread_mask[ch*4 +: 4] = mask;
    bus.in_warp_num[ch*3 +: 3]   = warp;
    bus.in_alu_result[ch*128 +: 128] = alu;
    bus.in_mem_result[ch*128 +: 128] = mem;
    bus.in_PC_next[ch*32 +: 32]  = pc;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Push on every channel for nval cycles, run ntot cycles, compare with a queue model.
  // The first plimit outputs must also follow the fixed 0,1,2,... rotation.
  task automatic burst(input int nval, input int ntot, input int plimit, output int nout);
    int prio;
    int seq [NS];
    int g;
    int idx;
    logic acc [NS];
    logic [31:0] exp_tag;
    prio = 0;
    nout = 0;
    for (int s = 0; s < NS; s++) seq[s] = 0;
    for (int c = 0; c < ntot; c++) begin
      clear_inputs();
      for (int s = 0; s < NS; s++) begin
        acc[s] = (c < nval) && (mq[s].size() != 2);
        if (c < nval)
          set_ch(s, 2'd1, 5'(s + 1), 4'hF, 3'(s),
                 lanes(32'h1000 * 32'(s + 1) + 32'h10 * 32'(seq[s])), '0, '0);
        chk($sformatf("burst_ready c%0d ch%0d", c, s), 128'(bus.in_ready[s]),
            128'(mq[s].size() != 2));
      end
      g = -1;
      for (int i = 0; i < NS; i++) begin
        idx = (prio + i) % NS;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      exp_tag = '0;
      if (g >= 0) begin
        exp_tag = mq[g].pop_front();
        prio = (g + 1) % NS;
      end
      for (int s = 0; s < NS; s++) begin
        if (acc[s]) begin
          mq[s].push_back(32'h1000 * 32'(s + 1) + 32'h10 * 32'(seq[s]));
          seq[s]++;
        end
      end
      @(posedge clk);
      #1;
      chk($sformatf("burst_valid c%0d", c), 128'(bus.out_valid), 128'(g >= 0));
      if (g >= 0) begin
        chk($sformatf("burst_sel c%0d", c), 128'(bus.out_sel), 128'(g));
        chk($sformatf("burst_rd c%0d", c), 128'(bus.out_rd), 128'(g + 1));
        chk($sformatf("burst_data c%0d", c), bus.out_write_data, lanes(exp_tag));
        if (nout < plimit)
          chk($sformatf("burst_rotation k%0d", nout), 128'(bus.out_sel), 128'(nout % NS));
        nout++;
      end
    end
  endtask

  initial begin
    logic [127:0] held_data;
    logic [4:0]   held_rd;
    int           nout;
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    clear_inputs();

    //            ch wb    rd     mask    warp  alu                                       mem                                                     pc            v     exp
    vecs[0] = '{0, 2'd1, 5'd5,  4'hF,   3'd2, {32'd4, 32'd3, 32'd2, 32'd1},            {4{32'hDEADBEEF}},                                      32'h100,      1'b1, {32'd4, 32'd3, 32'd2, 32'd1}};
    vecs[1] = '{1, 2'd3, 5'd1,  4'hF,   3'd5, {4{32'h11}},                             {4{32'h22}},                                            32'h80000010, 1'b1, {4{32'h80000010}}};
    vecs[2] = '{2, 2'd2, 5'd31, 4'b0101, 3'd7, {4{32'h33}},                             {32'hA3, 32'hA2, 32'hA1, 32'hA0},                      32'h0,        1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[3] = '{0, 2'd2, 5'd9,  4'b1000, 3'd0, {4{32'h55}},                             {32'hB0B0, 32'hB1B1, 32'hB2B2, 32'hB3B3},              32'h44,       1'b1, {32'hB0B0, 32'hB1B1, 32'hB2B2, 32'hB3B3}};
    vecs[4] = '{1, 2'd0, 5'd3,  4'hF,   3'd1, {4{32'h66}},                             {4{32'h77}},                                            32'h88,       1'b0, '0};
    vecs[5] = '{2, 2'd1, 5'd0,  4'hF,   3'd1, {4{32'h99}},                             {4{32'hAA}},                                            32'hBB,       1'b0, '0};
    vecs[6] = '{0, 2'd1, 5'd7,  4'h0,   3'd1, {4{32'hCC}},                             {4{32'hDD}},                                            32'hEE,       1'b0, '0};
    vecs[7] = '{2, 2'd1, 5'd12, 4'b0011, 3'd1, {32'hC3, 32'hC2, 32'hC1, 32'hC0},      {4{32'hFF}},                                            32'h0,        1'b1, {32'hC3, 32'hC2, 32'hC1, 32'hC0}};

    #1;
    chk("reset_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_ready", 128'(bus.in_ready), 128'(3'b111));
    chk("reset_data", bus.out_write_data, '0);
    chk("reset_sel", 128'(bus.out_sel), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    held_data = '0;
    held_rd   = '0;
    for (int v = 0; v < 8; v++) begin
      clear_inputs();
      set_ch(vecs[v].ch, vecs[v].wb, vecs[v].rd, vecs[v].mask, vecs[v].warp,
             vecs[v].alu, vecs[v].mem, vecs[v].pc);
      chk($sformatf("v%0d ready_pre", v), 128'(bus.in_ready), 128'(3'b111));
      @(posedge clk);
      #1;
      clear_inputs();
      chk($sformatf("v%0d lat_cycle1", v), 128'(bus.out_valid), 128'(0));
      chk($sformatf("v%0d ready_post", v), 128'(bus.in_ready), 128'(3'b111));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", v), 128'(bus.out_valid), 128'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) begin
        chk($sformatf("v%0d data", v), bus.out_write_data, vecs[v].exp_data);
        chk($sformatf("v%0d rd", v), 128'(bus.out_rd), 128'(vecs[v].rd));
        chk($sformatf("v%0d wb", v), 128'(bus.out_wb), 128'(vecs[v].wb));
        chk($sformatf("v%0d mask", v), 128'(bus.out_thread_mask), 128'(vecs[v].mask));
        chk($sformatf("v%0d warp", v), 128'(bus.out_warp_num), 128'(vecs[v].warp));
        chk($sformatf("v%0d sel", v), 128'(bus.out_sel), 128'(vecs[v].ch));
        held_data = vecs[v].exp_data;
        held_rd   = vecs[v].rd;
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d idle_valid", v), 128'(bus.out_valid), 128'(0));
      chk($sformatf("v%0d hold_data", v), bus.out_write_data, held_data);
      chk($sformatf("v%0d hold_rd", v), 128'(bus.out_rd), 128'(held_rd));
    end

    // Continuous three-channel burst, then drain
    reset_dut();
    burst(12, 20, 11, nout);
    chk("burst_idle_end", 128'(bus.out_valid), 128'(0));

    // Reset while FIFOs hold entries
    reset_dut();
    burst(4, 4, 0, nout);
    clear_inputs();
    #2 reset = 1'b1;
    #1;
    chk("midreset_valid", 128'(bus.out_valid), 128'(0));
    chk("midreset_ready", 128'(bus.in_ready), 128'(3'b111));
    chk("midreset_rd", 128'(bus.out_rd), 128'(0));
    chk("midreset_data", bus.out_write_data, '0);
    for (int s = 0; s < NS; s++) mq[s].delete();
    @(posedge clk);
    #1;
    chk("midreset_hold_valid", 128'(bus.out_valid), 128'(0));
    reset = 1'b0;
    burst(1, 6, 3, nout);
    chk("post_reset_outputs", 128'(nout), 128'(3));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
